// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry defaults, pixel types and packing helper
package fb_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 160;
  localparam int unsigned FB_HEIGHT_DEF = 120;
  localparam logic [15:0] FB_BASE_DEF   = 16'h0000;

  typedef logic [11:0] rgb444_t;
  typedef logic [15:0] fb_addr_t;

  // One RAM word per pixel: colour in the low 12 bits, top nibble unused
  function automatic logic [15:0] pack_pixel(input rgb444_t color);
    return {4'b0000, color};
  endfunction

endpackage

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - clipped solid-rectangle filler driving framebuffer RAM port A
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF,
  parameter fb_addr_t    FB_BASE   = FB_BASE_DEF,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] cmd_w,
  input  logic [Y_W-1:0] cmd_h,
  input  logic [11:0]    cmd_color,
  output logic [15:0]    wr_address,
  output logic [15:0]    wr_data,
  output logic           wren,
  output logic           busy,
  output logic           done
);

  localparam fb_addr_t WIDTH_A  = fb_addr_t'(FB_WIDTH);
  localparam fb_addr_t HEIGHT_A = fb_addr_t'(FB_HEIGHT);
  localparam fb_addr_t ONE_A    = 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [X_W-1:0] x_q, w_q;
  logic [Y_W-1:0] y_q, h_q;
  rgb444_t        color_q;

  fb_addr_t cw, ch, col, row, row_base;

  fb_addr_t x_a, y_a, w_a, h_a, room_x, room_y, cw_a, ch_a, setup_base;
  logic     empty, last_col, last_px;

  logic     wren_d, done_d;
  fb_addr_t addr_d;
  logic [15:0] data_d;

  // Clip the registered command against the screen and find the first row's base address
  always_comb begin
    x_a        = fb_addr_t'(x_q);
    y_a        = fb_addr_t'(y_q);
    w_a        = fb_addr_t'(w_q);
    h_a        = fb_addr_t'(h_q);
    empty      = (w_a == '0) || (h_a == '0) || (x_a >= WIDTH_A) || (y_a >= HEIGHT_A);
    room_x     = WIDTH_A - x_a;
    room_y     = HEIGHT_A - y_a;
    cw_a       = (w_a < room_x) ? w_a : room_x;
    ch_a       = (h_a < room_y) ? h_a : room_y;
    setup_base = FB_BASE + y_a * WIDTH_A;
    last_col   = (col == cw - ONE_A);
    last_px    = last_col && (row == ch - ONE_A);
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: empty rectangles skip straight from SETUP to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_SETUP;
      S_SETUP: state_nxt = empty ? S_DONE : S_WRITE;
      S_WRITE: if (last_px) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered RAM-port outputs; row changes jump to the next row's left edge
  always_comb begin
    wren_d = 1'b0;
    done_d = 1'b0;
    addr_d = wr_address;
    data_d = wr_data;
    case (state)
      S_SETUP: begin
        if (empty) begin
          done_d = 1'b1;
        end else begin
          wren_d = 1'b1;
          addr_d = setup_base + x_a;
          data_d = pack_pixel(color_q);
        end
      end
      S_WRITE: begin
        if (last_px) begin
          done_d = 1'b1;
        end else begin
          wren_d = 1'b1;
          addr_d = last_col ? (row_base + WIDTH_A + x_a) : (wr_address + ONE_A);
        end
      end
      default: ;
    endcase
  end

  // Output registers, cleared immediately by reset so an aborted fill stops writing at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wren       <= 1'b0;
      done       <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      wren       <= wren_d;
      done       <= done_d;
      wr_address <= addr_d;
      wr_data    <= data_d;
    end
  end

  // Command capture and column/row walk of the clipped rectangle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      cw       <= '0;
      ch       <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
          end
        end
        S_SETUP: begin
          cw       <= cw_a;
          ch       <= ch_a;
          col      <= '0;
          row      <= '0;
          row_base <= setup_base;
        end
        S_WRITE: begin
          if (last_col) begin
            col      <= '0;
            row      <= row + ONE_A;
            row_base <= row_base + WIDTH_A;
          end else begin
            col <= col + ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - randomized and directed self-checking bench for fb_rect_writer
module tb_fb_rect_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [11:0] cmd_color;
  logic [15:0] wr_address;
  logic [15:0] wr_data;
  logic        wren;
  logic        busy;
  logic        done;

  fb_rect_writer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_address(wr_address),
    .wr_data   (wr_data),
    .wren      (wren),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit wren;
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t q[$];
  int   wlog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0, acc_cnt = 0;
  int   done_cyc = 0, done_cnt = 0;
  int   first_wren = -1, last_wren = -1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Whole-rectangle expectation: one busy setup cycle, the clipped pixels in raster order, then done
  task automatic model_push(input int x, input int y, input int w, input int h, input int c);
    int cw, ch;
    exp_t e;
    e = '{wren: 0, addr: 0, data: 0, done: 0};
    q.push_back(e);
    if (w == 0 || h == 0 || x >= 160 || y >= 120) begin
      cw = 0;
      ch = 0;
    end else begin
      cw = (w < 160 - x) ? w : 160 - x;
      ch = (h < 120 - y) ? h : 120 - y;
    end
    for (int r = 0; r < ch; r++) begin
      for (int k = 0; k < cw; k++) begin
        e = '{wren: 1, addr: (y + r) * 160 + x + k, data: c, done: 0};
        q.push_back(e);
      end
    end
    e = '{wren: 0, addr: 0, data: 0, done: 1};
    q.push_back(e);
  endtask

  // Compare DUT outputs with the model every cycle, away from the rising edge
  always @(negedge clock) begin
    exp_t e;
    bit   idle;
    if (!reset_n) begin
      chk("rst_wren", wren, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      q.delete();
    end else begin
      idle = (q.size() == 0);
      if (idle) e = '{wren: 0, addr: 0, data: 0, done: 0};
      else e = q.pop_front();
      chk("wren", wren, e.wren);
      if (e.wren) begin
        chk("wr_address", wr_address, e.addr);
        chk("wr_data", wr_data, e.data);
      end
      chk("done", done, e.done);
      chk("busy", busy, !idle);
      chk("cmd_ready", cmd_ready, idle);
      if (wren) begin
        wlog.push_back(int'(wr_address));
        if (first_wren < 0) first_wren = cyc;
        last_wren = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (idle && cmd_valid) begin
        model_push(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h), int'(cmd_color));
        acc_cyc = cyc;
        acc_cnt++;
        first_wren = -1;
      end
    end
  end

  task automatic send(input int x, input int y, input int w, input int h, input int c);
    int a0, n;
    @(posedge clock);
    #1;
    cmd_x = x[7:0];
    cmd_y = y[6:0];
    cmd_w = w[7:0];
    cmd_h = h[6:0];
    cmd_color = c[11:0];
    cmd_valid = 1'b1;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    #1 cmd_valid = 1'b0;
    if (acc_cnt == a0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("done_seen", int'(done_cnt != d0), 1);
    @(negedge clock);
    #1;
  endtask

  initial begin
    int n, x, y, w, h;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_x = '0;
    cmd_y = '0;
    cmd_w = '0;
    cmd_h = '0;
    cmd_color = '0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("reset_wren", wren, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_writes", wlog.size(), 0);

    // Basic fill
    wlog.delete();
    send(2, 1, 3, 2, 12'hF00);
    wait_done();
    chk("fill_count", wlog.size(), 6);
    if (wlog.size() == 6) begin
      chk("fill_a0", wlog[0], 162);
      chk("fill_a1", wlog[1], 163);
      chk("fill_a2", wlog[2], 164);
      chk("fill_a3", wlog[3], 322);
      chk("fill_a4", wlog[4], 323);
      chk("fill_a5", wlog[5], 324);
    end
    chk("fill_latency", first_wren - acc_cyc, 2);
    chk("fill_done_after_last", done_cyc - last_wren, 1);
    chk("fill_done_latency", done_cyc - acc_cyc, 8);
    chk("fill_data", wr_data, 16'h0F00);

    // Corner clip
    wlog.delete();
    send(158, 119, 5, 4, 12'h0AB);
    wait_done();
    chk("clip_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("clip_a0", wlog[0], 19198);
      chk("clip_a1", wlog[1], 19199);
    end

    // Empty rectangles
    wlog.delete();
    send(10, 10, 0, 5, 12'h123);
    wait_done();
    chk("empty_w_writes", wlog.size(), 0);
    chk("empty_w_latency", done_cyc - acc_cyc, 2);
    wlog.delete();
    send(160, 10, 4, 5, 12'h123);
    wait_done();
    chk("empty_x_writes", wlog.size(), 0);
    chk("empty_x_latency", done_cyc - acc_cyc, 2);

    // Back-to-back: second command held during busy
    wlog.delete();
    send(3, 4, 3, 2, 12'h00F);
    send(10, 10, 2, 2, 12'h0F0);
    chk("b2b_accept_after_done", acc_cyc - done_cyc, 1);
    wait_done();
    chk("b2b_count", wlog.size(), 10);

    // Randomized commands, sometimes back-to-back
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      x = $urandom_range(0, 175);
      y = $urandom_range(0, 127);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 8);
      if ($urandom_range(0, 5) == 0) begin
        w = 255;
        h = $urandom_range(0, 2);
      end else if ($urandom_range(0, 5) == 0) begin
        h = 127;
        w = $urandom_range(0, 2);
      end
      send(x, y, w, h, int'($urandom_range(0, 4095)));
    end
    n = 0;
    while (q.size() != 0 && n < 40000) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("random_drained", q.size(), 0);

    // Reset mid-fill after three writes
    wlog.delete();
    send(0, 0, 10, 10, 12'h0F0);
    n = 0;
    while (wlog.size() < 3 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("mid_writes", wlog.size(), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_wren", wren, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("abort_writes", wlog.size(), 3);
    wlog.delete();
    send(20, 30, 4, 3, 12'hABC);
    wait_done();
    chk("post_reset_count", wlog.size(), 12);
    if (wlog.size() == 12) begin
      chk("post_reset_first", wlog[0], 30 * 160 + 20);
      chk("post_reset_last", wlog[11], 32 * 160 + 23);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
